// File: rtl/clk_div_meter.sv
// Measures a divided clock in master-clock cycles: level lengths, period ratio,
// lock, duty error and loss-of-clock timeout. All outputs registered.
module clk_div_meter #(
  parameter int unsigned CNT_W    = 16,
  parameter int unsigned LOCK_CNT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clk_in,
  output logic [CNT_W-1:0] high_len,
  output logic [CNT_W-1:0] low_len,
  output logic [CNT_W-1:0] div_ratio,
  output logic             ratio_valid,
  output logic             locked,
  output logic             duty_err,
  output logic             timeout
);

  localparam int unsigned MATCH_W = $clog2(LOCK_CNT + 1);
  localparam logic [CNT_W-1:0]   CNT_MAX  = '1;
  localparam logic [MATCH_W-1:0] MATCH_LK = MATCH_W'(LOCK_CNT);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ARM  = 2'd1;
  localparam logic [1:0] ST_MEAS = 2'd2;
  localparam logic [1:0] ST_TMO  = 2'd3;

  logic             s1, s2, s_d;
  logic [1:0]       state, state_n;
  logic [CNT_W-1:0] run_cnt, run_cnt_n;
  logic             got_high, got_high_n, got_low, got_low_n;
  logic [MATCH_W-1:0] match_cnt, match_cnt_n;
  logic [CNT_W-1:0] high_len_n, low_len_n, div_ratio_n;
  logic             ratio_valid_n, locked_n, duty_err_n, timeout_n;

  logic             rise, fall, lvl_edge, run_sat, tmo_go;
  logic [CNT_W-1:0] ratio_sum, duty_diff;

  assign rise      = s2 & ~s_d;
  assign fall      = ~s2 & s_d;
  assign lvl_edge  = rise | fall;
  assign run_sat   = (run_cnt == CNT_MAX);
  assign ratio_sum = high_len + run_cnt;
  assign duty_diff = (high_len >= run_cnt) ? (high_len - run_cnt) : (run_cnt - high_len);
  // A level held to saturation with no edge that cycle means the clock is lost
  assign tmo_go    = run_sat && !lvl_edge && ((state == ST_ARM) || (state == ST_MEAS));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1          <= 1'b0;
      s2          <= 1'b0;
      s_d         <= 1'b0;
      state       <= ST_IDLE;
      run_cnt     <= '0;
      got_high    <= 1'b0;
      got_low     <= 1'b0;
      match_cnt   <= '0;
      high_len    <= '0;
      low_len     <= '0;
      div_ratio   <= '0;
      ratio_valid <= 1'b0;
      locked      <= 1'b0;
      duty_err    <= 1'b0;
      timeout     <= 1'b0;
    end else begin
      s1          <= clk_in;
      s2          <= s1;
      s_d         <= s2;
      state       <= state_n;
      run_cnt     <= run_cnt_n;
      got_high    <= got_high_n;
      got_low     <= got_low_n;
      match_cnt   <= match_cnt_n;
      high_len    <= high_len_n;
      low_len     <= low_len_n;
      div_ratio   <= div_ratio_n;
      ratio_valid <= ratio_valid_n;
      locked      <= locked_n;
      duty_err    <= duty_err_n;
      timeout     <= timeout_n;
    end
  end

  always_comb begin
    state_n       = state;
    got_high_n    = got_high;
    got_low_n     = got_low;
    match_cnt_n   = match_cnt;
    high_len_n    = high_len;
    low_len_n     = low_len;
    div_ratio_n   = div_ratio;
    ratio_valid_n = 1'b0;
    locked_n      = locked;
    duty_err_n    = duty_err;
    timeout_n     = timeout;

    // The edge cycle is the first cycle of the new level
    if (lvl_edge)     run_cnt_n = CNT_W'(1);
    else if (run_sat) run_cnt_n = run_cnt;
    else              run_cnt_n = run_cnt + CNT_W'(1);

    case (state)
      ST_IDLE: begin
        if (lvl_edge) begin
          state_n    = ST_ARM;
          got_high_n = 1'b0;
          got_low_n  = 1'b0;
        end
      end
      ST_ARM: begin
        if (lvl_edge) begin
          if (fall) begin
            high_len_n = run_cnt;
            got_high_n = 1'b1;
          end else begin
            low_len_n = run_cnt;
            got_low_n = 1'b1;
          end
          if (got_high_n && got_low_n) state_n = ST_MEAS;
        end
      end
      ST_MEAS: begin
        if (fall) high_len_n = run_cnt;
        if (rise) begin
          low_len_n     = run_cnt;
          div_ratio_n   = ratio_sum;
          ratio_valid_n = 1'b1;
          duty_err_n    = (duty_diff > CNT_W'(1));
          if (ratio_sum != div_ratio)    match_cnt_n = MATCH_W'(1);
          else if (match_cnt < MATCH_LK) match_cnt_n = match_cnt + MATCH_W'(1);
          locked_n = (match_cnt_n >= MATCH_LK);
        end
      end
      ST_TMO: begin
        if (lvl_edge) begin
          state_n    = ST_ARM;
          timeout_n  = 1'b0;
          got_high_n = 1'b0;
          got_low_n  = 1'b0;
        end
      end
      default: state_n = ST_IDLE;
    endcase

    if (tmo_go) begin
      state_n     = ST_TMO;
      timeout_n   = 1'b1;
      locked_n    = 1'b0;
      match_cnt_n = '0;
    end
  end

endmodule

// File: tb/tb_clk_div_meter.sv
// Bench for clk_div_meter: phase table of divided-clock patterns with a level-based
// reference model feeding a scoreboard, plus timeout and async-reset sequences.
module tb_clk_div_meter;

  localparam int CNT_W = 8;
  localparam int MAX   = 255;
  localparam int LOCK  = 4;

  logic             clk;
  logic             rst_n;
  logic             clk_in;
  logic [CNT_W-1:0] high_len, low_len, div_ratio;
  logic             ratio_valid, locked, duty_err, timeout;

  clk_div_meter #(.CNT_W(CNT_W), .LOCK_CNT(LOCK)) dut (
    .clk(clk), .rst_n(rst_n), .clk_in(clk_in),
    .high_len(high_len), .low_len(low_len), .div_ratio(div_ratio),
    .ratio_valid(ratio_valid), .locked(locked), .duty_err(duty_err),
    .timeout(timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int h; int l; int r; int d; int lk;
  } exp_t;

  typedef struct {
    int hi; int lo; int reps;
    int exp_ratio; int exp_duty; int exp_locked;
  } phase_t;

  exp_t   sb[$];
  phase_t tbl[7];
  int     checks   = 0;
  int     failures = 0;

  // Reference model state, advanced at level granularity
  int m_val, m_len, m_state, m_gh, m_gl, m_mh, m_ml, m_match, m_prev;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_val = 0; m_len = 0; m_state = 0; m_gh = 0; m_gl = 0;
    m_mh = 0; m_ml = 0; m_match = 0; m_prev = 0;
  endtask

  // States: 0 idle, 1 arm, 2 meas, 3 lost clock
  task automatic model_edge(input int val, input int len);
    int l_sat, r, dd;
    exp_t e;
    l_sat = (len > MAX) ? MAX : len;
    if ((m_state == 1 || m_state == 2) && len > MAX) begin
      m_state = 3;
      m_match = 0;
    end
    case (m_state)
      0, 3: begin m_state = 1; m_gh = 0; m_gl = 0; end
      1: begin
        if (val == 1) begin m_mh = l_sat; m_gh = 1; end
        else          begin m_ml = l_sat; m_gl = 1; end
        if (m_gh == 1 && m_gl == 1) m_state = 2;
      end
      default: begin
        if (val == 1) m_mh = l_sat;
        else begin
          m_ml = l_sat;
          r  = (m_mh + l_sat) % (MAX + 1);
          dd = (m_mh > l_sat) ? m_mh - l_sat : l_sat - m_mh;
          if (r != m_prev) m_match = 1;
          else if (m_match < LOCK) m_match = m_match + 1;
          m_prev = r;
          e.h = m_mh; e.l = l_sat; e.r = r; e.d = (dd > 1) ? 1 : 0;
          e.lk = (m_match >= LOCK) ? 1 : 0;
          sb.push_back(e);
        end
      end
    endcase
  endtask

  task automatic drive_level(input int v, input int n);
    if (v != m_val) begin
      model_edge(m_val, m_len);
      m_len = n;
    end else begin
      m_len = m_len + n;
    end
    m_val  = v;
    clk_in = 1'(v);
    repeat (n) @(negedge clk);
  endtask

  task automatic run_phase(input int i);
    for (int k = 0; k < tbl[i].reps; k++) begin
      drive_level(1, tbl[i].hi);
      drive_level(0, tbl[i].lo);
    end
    check($sformatf("ph%0d_ratio", i), int'(div_ratio), tbl[i].exp_ratio);
    check($sformatf("ph%0d_duty", i), int'(duty_err), tbl[i].exp_duty);
    check($sformatf("ph%0d_locked", i), int'(locked), tbl[i].exp_locked);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_high_len"}, int'(high_len), 0);
    check({tag, "_low_len"}, int'(low_len), 0);
    check({tag, "_div_ratio"}, int'(div_ratio), 0);
    check({tag, "_flags"}, int'({ratio_valid, locked, duty_err, timeout}), 0);
  endtask

  // Scoreboard: every ratio_valid pulse consumes one expected period
  always @(negedge clk) begin
    if (rst_n && ratio_valid) begin
      if (sb.size() == 0) begin
        check("spurious_ratio_valid", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("sb_high_len", int'(high_len), e.h);
        check("sb_low_len", int'(low_len), e.l);
        check("sb_div_ratio", int'(div_ratio), e.r);
        check("sb_duty_err", int'(duty_err), e.d);
        check("sb_locked", int'(locked), e.lk);
      end
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{hi: 3, lo: 3, reps: 8, exp_ratio: 6,  exp_duty: 0, exp_locked: 1};
    tbl[1] = '{hi: 5, lo: 5, reps: 6, exp_ratio: 10, exp_duty: 0, exp_locked: 1};
    tbl[2] = '{hi: 1, lo: 1, reps: 8, exp_ratio: 2,  exp_duty: 0, exp_locked: 1};
    tbl[3] = '{hi: 2, lo: 5, reps: 3, exp_ratio: 7,  exp_duty: 1, exp_locked: 0};
    tbl[4] = '{hi: 3, lo: 4, reps: 4, exp_ratio: 7,  exp_duty: 0, exp_locked: 1};
    tbl[5] = '{hi: 3, lo: 3, reps: 8, exp_ratio: 6,  exp_duty: 0, exp_locked: 1};
    tbl[6] = '{hi: 3, lo: 3, reps: 8, exp_ratio: 6,  exp_duty: 0, exp_locked: 1};

    model_reset();
    rst_n  = 1'b0;
    clk_in = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 5; i++) run_phase(i);

    // Clock stuck high: timeout after 255 cycles, ratio/levels held
    drive_level(1, 250);
    check("tmo_not_yet", int'(timeout), 0);
    drive_level(1, 10);
    check("tmo_set", int'(timeout), 1);
    check("tmo_locked", int'(locked), 0);
    check("tmo_ratio_hold", int'(div_ratio), 7);
    check("tmo_high_hold", int'(high_len), 3);
    check("tmo_low_hold", int'(low_len), 4);
    drive_level(0, 3);
    check("tmo_cleared", int'(timeout), 0);
    run_phase(5);

    // Async reset mid-level while locked
    drive_level(1, 5);
    #2 rst_n = 1'b0;
    #1 check_all_zero("async_rst");
    check("sb_empty_at_reset", sb.size(), 0);
    sb.delete();
    model_reset();
    clk_in = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    run_phase(6);

    repeat (10) @(negedge clk);
    check("sb_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
